// File: rtl/expand_key_seq_if.sv
// SRAM word-pair port and feistel engine port between expand_key_seq (master) and its neighbours (slave).
interface expand_key_seq_if #(
  parameter int ADDR_W = 12
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic              mem_wr;
  logic [31:0]       mem_wdata_l;
  logic [31:0]       mem_wdata_r;
  logic [31:0]       mem_rdata_l;
  logic [31:0]       mem_rdata_r;
  logic              mem_grant_fs;
  logic              fs_start;
  logic [31:0]       fs_l;
  logic [31:0]       fs_r;
  logic              fs_done;
  logic [31:0]       fs_res_l;
  logic [31:0]       fs_res_r;

  // Handshakes: mem_rd/mem_wr are single-cycle commands the SRAM always accepts (no ready);
  // read data is valid exactly one cycle after mem_rd. fs_start is a one-cycle request;
  // fs_done is a one-cycle response whose fs_res_* are valid only in that cycle.
  modport master (
    output mem_addr, mem_rd, mem_wr, mem_wdata_l, mem_wdata_r, mem_grant_fs,
    output fs_start, fs_l, fs_r,
    input  mem_rdata_l, mem_rdata_r, fs_done, fs_res_l, fs_res_r
  );

  modport slave (
    input  mem_addr, mem_rd, mem_wr, mem_wdata_l, mem_wdata_r, mem_grant_fs,
    input  fs_start, fs_l, fs_r,
    output mem_rdata_l, mem_rdata_r, fs_done, fs_res_l, fs_res_r
  );
endinterface

// File: rtl/expand_key_seq.sv
// Eksblowfish ExpandKey / ExpandKey0 sequencer: key XOR into P, then chained salted encrypts into P and S.
// Optional busy-cycle performance counter enabled by defining EXPANDKEY_PERF_CNT_EN.
module expand_key_seq #(
  parameter int P_WORDS   = 18,
  parameter int S_WORDS   = 1024,
  parameter int P_BASE    = 4000,
  parameter int S_BASE    = 0,
  parameter int ADDR_W    = 12,
  parameter int KEY_BYTES = 72,
  localparam int KW       = $clog2(KEY_BYTES)
) (
  input  logic                clk,
  input  logic                reset_l,
  input  logic                start,
  input  logic                zero_salt,
  input  logic [127:0]        salt,
  input  logic [KW:0]         key_len,
  output logic [KW-1:0]       key_addr,
  input  logic [7:0]          key_byte,
  expand_key_seq_if.master    bus,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [31:0]         busy_cycles
);

  localparam int P_PAIRS = P_WORDS / 2;
  localparam int NB      = (P_WORDS + S_WORDS) / 2;
  localparam int BW      = $clog2(NB + 1);
  localparam int PW      = $clog2(P_PAIRS + 1);

  typedef enum logic [2:0] {
    IDLE, KFETCH, PRD, PWR, ENC_GO, ENC_WAIT, ENC_WB, DONE
  } state_t;

  state_t              state;
  logic [KW-1:0]       kidx;
  logic [2:0]          kcnt;
  logic [PW-1:0]       pair;
  logic [BW-1:0]       blk;
  logic [63:0]         acc;
  logic [31:0]         l_q, r_q;
  logic [127:0]        salt_q;
  logic [KW:0]         klen_q;

  logic                busy_q, done_q, err_q;
  logic                mem_rd_q, mem_wr_q, grant_q, fs_start_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [31:0]         wdata_l_q, wdata_r_q;
  logic [31:0]         fs_l_q, fs_r_q;

  // Blocks below P_PAIRS land in the P-array, the rest walk the S-boxes from S_BASE.
  function automatic logic [ADDR_W-1:0] blk_addr(input logic [BW-1:0] b);
    if (b < BW'(P_PAIRS))
      return ADDR_W'(P_BASE) + ADDR_W'({b, 1'b0});
    else
      return ADDR_W'(S_BASE) + ADDR_W'({b - BW'(P_PAIRS), 1'b0});
  endfunction

  // Even blocks mix the upper salt half, odd blocks the lower half; salt_q is zero for ExpandKey0.
  function automatic logic [63:0] salt_mix(input logic [31:0] l, input logic [31:0] r,
                                           input logic b_odd);
    if (b_odd)
      return {l ^ salt_q[63:32], r ^ salt_q[31:0]};
    else
      return {l ^ salt_q[127:96], r ^ salt_q[95:64]};
  endfunction

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state      <= IDLE;
      kidx       <= '0;
      kcnt       <= '0;
      pair       <= '0;
      blk        <= '0;
      acc        <= '0;
      l_q        <= '0;
      r_q        <= '0;
      salt_q     <= '0;
      klen_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      mem_rd_q   <= 1'b0;
      mem_wr_q   <= 1'b0;
      grant_q    <= 1'b0;
      fs_start_q <= 1'b0;
      mem_addr_q <= '0;
      wdata_l_q  <= '0;
      wdata_r_q  <= '0;
      fs_l_q     <= '0;
      fs_r_q     <= '0;
    end else begin
      // Strobes are asserted for exactly the state being entered.
      mem_rd_q   <= 1'b0;
      mem_wr_q   <= 1'b0;
      grant_q    <= 1'b0;
      fs_start_q <= 1'b0;
      done_q     <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            salt_q <= zero_salt ? '0 : salt;
            klen_q <= key_len;
            kidx   <= '0;
            kcnt   <= '0;
            pair   <= '0;
            blk    <= '0;
            acc    <= '0;
            busy_q <= 1'b1;
            if (key_len == '0 || key_len > (KW+1)'(KEY_BYTES)) begin
              state  <= DONE;
              done_q <= 1'b1;
              err_q  <= 1'b1;
            end else begin
              state  <= KFETCH;
              err_q  <= 1'b0;
            end
          end
        end
        KFETCH: begin
          acc <= {acc[55:0], key_byte};
          // The key index wraps cyclically and carries over into the next pair.
          if ({1'b0, kidx} == klen_q - (KW+1)'(1))
            kidx <= '0;
          else
            kidx <= kidx + KW'(1);
          kcnt <= kcnt + 3'd1;
          if (kcnt == 3'd7) begin
            state      <= PRD;
            mem_rd_q   <= 1'b1;
            mem_addr_q <= blk_addr(BW'(pair));
          end
        end
        PRD: begin
          state    <= PWR;
          mem_wr_q <= 1'b1;
        end
        PWR: begin
          if (pair != PW'(P_PAIRS - 1)) begin
            pair  <= pair + PW'(1);
            state <= KFETCH;
          end else begin
            l_q              <= '0;
            r_q              <= '0;
            {fs_l_q, fs_r_q} <= salt_mix(32'd0, 32'd0, 1'b0);
            fs_start_q       <= 1'b1;
            state            <= ENC_GO;
          end
        end
        ENC_GO: begin
          state   <= ENC_WAIT;
          grant_q <= 1'b1;
        end
        ENC_WAIT: begin
          if (bus.fs_done) begin
            l_q        <= bus.fs_res_l;
            r_q        <= bus.fs_res_r;
            wdata_l_q  <= bus.fs_res_l;
            wdata_r_q  <= bus.fs_res_r;
            mem_addr_q <= blk_addr(blk);
            mem_wr_q   <= 1'b1;
            state      <= ENC_WB;
          end else begin
            grant_q <= 1'b1;
          end
        end
        ENC_WB: begin
          if (blk == BW'(NB - 1)) begin
            state  <= DONE;
            done_q <= 1'b1;
          end else begin
            blk              <= blk + BW'(1);
            {fs_l_q, fs_r_q} <= salt_mix(l_q, r_q, ~blk[0]);
            fs_start_q       <= 1'b1;
            state            <= ENC_GO;
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign key_addr         = kidx;
  assign busy             = busy_q;
  assign done             = done_q;
  assign err              = err_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_rd       = mem_rd_q;
  assign bus.mem_wr       = mem_wr_q;
  assign bus.mem_grant_fs = grant_q;
  assign bus.fs_start     = fs_start_q;
  assign bus.fs_l         = fs_l_q;
  assign bus.fs_r         = fs_r_q;

  // The P-array update is read-modify-write: read data arrives in PWR and is XORed on its way out.
  assign bus.mem_wdata_l  = (state == PWR) ? (bus.mem_rdata_l ^ acc[63:32]) : wdata_l_q;
  assign bus.mem_wdata_r  = (state == PWR) ? (bus.mem_rdata_r ^ acc[31:0])  : wdata_r_q;

`ifdef EXPANDKEY_PERF_CNT_EN
  logic [31:0] perf_q;

  // The accepted start cycle counts as the first busy cycle of the run.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l)
      perf_q <= '0;
    else if (state == IDLE && start)
      perf_q <= 32'd1;
    else if (busy_q && perf_q != 32'hFFFF_FFFF)
      perf_q <= perf_q + 32'd1;
  end

  assign busy_cycles = perf_q;
`else
  assign busy_cycles = '0;
`endif

endmodule

// File: tb/tb_expand_key_seq.sv
// Directed bench for expand_key_seq: stub feistel ({R+1, L} after 3 cycles) and a zero-initialised SRAM model.
`timescale 1ns/1ps
module tb_expand_key_seq;
  localparam int ADDR_W    = 12;
  localparam int KEY_BYTES = 72;
  localparam int KW        = $clog2(KEY_BYTES);
  localparam int W         = ADDR_W + 64;

  logic          clk = 1'b0;
  logic          reset_l = 1'b0;
  logic          start = 1'b0;
  logic          zero_salt = 1'b0;
  logic [127:0]  salt = '0;
  logic [KW:0]   key_len = '0;
  logic [KW-1:0] key_addr;
  logic [7:0]    key_byte;
  logic          busy, done, err;
  logic [31:0]   busy_cycles;

  expand_key_seq_if #(.ADDR_W(ADDR_W)) bus ();

  expand_key_seq #(
    .P_WORDS(18), .S_WORDS(1024), .P_BASE(4000), .S_BASE(0),
    .ADDR_W(ADDR_W), .KEY_BYTES(KEY_BYTES)
  ) dut (
    .clk(clk), .reset_l(reset_l), .start(start), .zero_salt(zero_salt), .salt(salt),
    .key_len(key_len), .key_addr(key_addr), .key_byte(key_byte), .bus(bus),
    .busy(busy), .done(done), .err(err), .busy_cycles(busy_cycles)
  );

  // ---------------- clock / models ----------------
  always #5 clk = ~clk;

  logic [7:0]  key_mem [0:127];
  assign key_byte = key_mem[key_addr];

  logic [31:0] sram [0:4095];
  logic        sram_clr = 1'b0;
  always @(posedge clk) begin
    if (sram_clr) begin
      for (int i = 0; i < 4096; i++) sram[i] <= '0;
    end else begin
      if (bus.mem_rd) begin
        bus.mem_rdata_l <= sram[bus.mem_addr];
        bus.mem_rdata_r <= sram[bus.mem_addr + 12'd1];
      end
      if (bus.mem_wr) begin
        sram[bus.mem_addr]         <= bus.mem_wdata_l;
        sram[bus.mem_addr + 12'd1] <= bus.mem_wdata_r;
      end
    end
  end

  logic [2:0]  sd = '0;
  logic [31:0] stub_l = '0, stub_r = '0;
  logic        spur = 1'b0;
  always @(posedge clk) begin
    sd <= {sd[1:0], bus.fs_start};
    if (bus.fs_start) begin
      stub_l <= bus.fs_r + 32'd1;
      stub_r <= bus.fs_l;
    end
  end
  assign bus.fs_done  = sd[2] | spur;
  assign bus.fs_res_l = stub_l;
  assign bus.fs_res_r = stub_r;

  // ---------------- monitor ----------------
  logic [W-1:0] wr_log[$];
  logic [63:0]  fs_log[$];
  int           done_cnt = 0;
  int           viol = 0;
  always @(negedge clk) begin
    if (bus.mem_wr) wr_log.push_back({bus.mem_addr, bus.mem_wdata_l, bus.mem_wdata_r});
    if (bus.fs_start) fs_log.push_back({bus.fs_l, bus.fs_r});
    if (done) done_cnt++;
    if ((bus.mem_rd && bus.mem_wr) || (bus.mem_grant_fs && (bus.mem_rd || bus.mem_wr))) viol++;
  end

  // ---------------- scoreboard ----------------
  int           n_cmp = 0;
  int           n_bad = 0;
  logic [W-1:0] exp_q[$];
  int           idx_q[$];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input int idx, input logic [ADDR_W-1:0] a, input logic [31:0] l,
                          input logic [31:0] r);
    exp_q.push_back({a, l, r});
    idx_q.push_back(idx);
  endtask

  task automatic drain_exp(input string tag, input int base);
    logic [W-1:0] e;
    int           i;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      i = idx_q.pop_front();
      if (base + i < wr_log.size())
        check($sformatf("%s_wr%0d", tag, i), wr_log[base + i], e);
      else
        check($sformatf("%s_wr%0d_missing", tag, i), wr_log.size(), base + i + 1);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_sram();
    sram_clr = 1'b1;
    @(negedge clk);
    sram_clr = 1'b0;
  endtask

  // Returns the number of cycles from the start cycle to the done cycle (done lands on cycle cyc+1
  // when the start cycle is numbered 1).
  task automatic run(input string tag, input logic zs, input logic [127:0] s,
                     input logic [KW:0] klen, output int cyc);
    @(negedge clk);
    zero_salt = zs;
    salt      = s;
    key_len   = klen;
    start     = 1'b1;
    cyc       = 0;
    while (1) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) start = 1'b0;
      if (done || cyc > 5000) break;
    end
    check({tag, "_done_seen"}, done, 1'b1);
  endtask

  logic [31:0] exp_perf;

  initial begin
    int cyc, base_w, base_f, seen, dc;

    for (int i = 0; i < 128; i++) key_mem[i] = 8'(i);
    bus.mem_rdata_l = '0;
    bus.mem_rdata_r = '0;
    sram_clr = 1'b1;

    // reset state
    repeat (3) @(negedge clk);
    sram_clr = 1'b0;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_mem_rd", bus.mem_rd, 1'b0);
    check("rst_mem_wr", bus.mem_wr, 1'b0);
    check("rst_fs_start", bus.fs_start, 1'b0);
    check("rst_grant", bus.mem_grant_fs, 1'b0);
    check("rst_addr", bus.mem_addr, 12'd0);
    check("rst_key_addr", key_addr, '0);
    reset_l = 1'b1;
    repeat (2) @(negedge clk);

    // 1: reset asserted in PWR aborts the run
    zero_salt = 1'b1; key_len = 8; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.mem_wr) begin seen = 1; break; end
      @(negedge clk);
    end
    check("t1_pwr_seen", seen, 1);
    dc = done_cnt;
    reset_l = 1'b0;
    #1;
    check("t1_busy", busy, 1'b0);
    check("t1_mem_wr", bus.mem_wr, 1'b0);
    check("t1_addr", bus.mem_addr, 12'd0);
    check("t1_key_addr", key_addr, '0);
    check("t1_wdata_l", bus.mem_wdata_l, 32'd0);
    check("t1_busy_cycles", busy_cycles, 32'd0);
    repeat (3) @(negedge clk);
    reset_l = 1'b1;
    repeat (5) @(negedge clk);
    check("t1_idle_after", busy, 1'b0);
    check("t1_no_done", done_cnt, dc);

    // 3: invalid key lengths
    base_w = wr_log.size();
    run("t3_len0", 1'b0, '0, 0, cyc);
    check("t3_len0_latency", cyc, 1);
    check("t3_len0_err", err, 1'b1);
    repeat (3) @(negedge clk);
    check("t3_err_hold", err, 1'b1);
    check("t3_idle", busy, 1'b0);
    run("t3_len73", 1'b0, '0, 73, cyc);
    check("t3_len73_latency", cyc, 1);
    check("t3_len73_err", err, 1'b1);
    check("t3_no_writes", wr_log.size(), base_w);

    // 2: key "ab\0", length 3, ExpandKey0 (salt input ignored)
    clear_sram();
    key_mem[0] = 8'h61; key_mem[1] = 8'h62; key_mem[2] = 8'h00;
    base_w = wr_log.size();
    base_f = fs_log.size();
    run("t2", 1'b1, {4{32'hFFFF_FFFF}}, 3, cyc);
    check("t2_err", err, 1'b0);
    check("t2_fs0", fs_log[base_f], 64'h0);
    check("t2_fs1", fs_log[base_f + 1], {32'd1, 32'd0});
    push_exp(0,  12'd4000, 32'h6162_0061, 32'h6200_6162);
    push_exp(1,  12'd4002, 32'h0061_6200, 32'h6162_0061);
    push_exp(9,  12'd4000, 32'h0000_0001, 32'h0000_0000);
    push_exp(10, 12'd4002, 32'h0000_0001, 32'h0000_0001);
    drain_exp("t2", base_w);
    check("t2_wr_count", wr_log.size() - base_w, 530);

    // 4 + 6: salted run at the defaults
    clear_sram();
    for (int i = 0; i < 128; i++) key_mem[i] = 8'(i);
    base_w = wr_log.size();
    base_f = fs_log.size();
    viol = 0;
    run("t4", 1'b0, 128'h01234567_FEDCBA98_76543210_89ABCDEF, 72, cyc);
    check("t4_done_cycle", cyc + 1, 2697);
    check("t4_wr_count", wr_log.size() - base_w, 530);
    check("t4_fs0", fs_log[base_f], {32'h0123_4567, 32'hFEDC_BA98});
    check("t4_fs1_low_salt", fs_log[base_f + 1], {32'h8888_8889, 32'h8888_8888});
    check("t4_fs2", fs_log[base_f + 2], {32'h89AB_CDEE, 32'h7654_3211});
    for (int k = 0; k < 9; k++)
      push_exp(k, 12'(4000 + 2 * k),
               {8'(8 * k), 8'(8 * k + 1), 8'(8 * k + 2), 8'(8 * k + 3)},
               {8'(8 * k + 4), 8'(8 * k + 5), 8'(8 * k + 6), 8'(8 * k + 7)});
    push_exp(9,  12'd4000, 32'hFEDC_BA99, 32'h0123_4567);
    push_exp(10, 12'd4002, 32'h8888_8889, 32'h8888_8889);
    push_exp(11, 12'd4004, 32'h7654_3212, 32'h89AB_CDEE);
    drain_exp("t4", base_w);
    if (wr_log.size() >= base_w + 530) begin
      check("t4_first_s_addr", wr_log[base_w + 18][W-1:64], 12'd0);
      check("t4_last_addr", wr_log[base_w + 529][W-1:64], 12'd1022);
    end else begin
      check("t4_log_short", wr_log.size() - base_w, 530);
    end
    check("t4_bus_rules", viol, 0);
    @(negedge clk);
`ifdef EXPANDKEY_PERF_CNT_EN
    exp_perf = 32'd2697;
`else
    exp_perf = 32'd0;
`endif
    repeat (2) @(negedge clk);
    check("t6_busy_cycles", busy_cycles, exp_perf);

    // 5: start during ENC_WAIT and fs_done during PRD are both ignored
    base_w = wr_log.size();
    fork
      run("t5", 1'b1, '0, 5, cyc);
      begin
        for (int i = 0; i < 100; i++) begin
          @(negedge clk);
          if (bus.mem_rd) break;
        end
        spur = 1'b1;
        @(negedge clk);
        spur = 1'b0;
      end
      begin
        for (int i = 0; i < 300; i++) begin
          @(negedge clk);
          if (bus.mem_grant_fs) break;
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    join
    check("t5_done_cycle", cyc + 1, 2697);
    check("t5_wr_count", wr_log.size() - base_w, 530);
    repeat (3) @(negedge clk);
    check("t5_idle_after", busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
